// File: rtl/mux_arbiter.sv
// Round-robin arbiter for a 2:1 mux datapath: registered grants and mux select,
// with a bounded hold time that forces a hand-over when the other side is waiting.
module mux_arbiter #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_grant0,
  output logic o_grant1,
  output logic o_control,
  output logic o_busy,
  output logic o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_G0   = 2'd1,
    S_G1   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             r_control;
  logic             r_timeout;
  logic             r_grant0;
  logic             r_grant1;
  logic             r_busy;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_last_next;
  logic             w_control_next;
  logic             w_timeout_next;

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_last_next    = r_last;
    w_control_next = r_control;
    w_timeout_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        // r_last names the requester served most recently, so a tie goes to the other
        if (i_req0 && i_req1) begin
          w_state_next   = r_last ? S_G0 : S_G1;
          w_control_next = ~r_last;
        end else if (i_req0) begin
          w_state_next   = S_G0;
          w_control_next = 1'b0;
        end else if (i_req1) begin
          w_state_next   = S_G1;
          w_control_next = 1'b1;
        end
      end
      S_G0: begin
        if (!i_req0) begin
          w_last_next = 1'b0;
          w_cnt_next  = '0;
          if (i_req1) begin
            w_state_next   = S_G1;
            w_control_next = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (i_req1) begin
          if (r_cnt == CNT_MAX) begin
            w_state_next   = S_G1;
            w_control_next = 1'b1;
            w_last_next    = 1'b0;
            w_timeout_next = 1'b1;
            w_cnt_next     = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      S_G1: begin
        if (!i_req1) begin
          w_last_next = 1'b1;
          w_cnt_next  = '0;
          if (i_req0) begin
            w_state_next   = S_G0;
            w_control_next = 1'b0;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (i_req0) begin
          if (r_cnt == CNT_MAX) begin
            w_state_next   = S_G0;
            w_control_next = 1'b0;
            w_last_next    = 1'b1;
            w_timeout_next = 1'b1;
            w_cnt_next     = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_control <= 1'b0;
      r_timeout <= 1'b0;
      r_grant0  <= 1'b0;
      r_grant1  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_last    <= w_last_next;
      r_control <= w_control_next;
      r_timeout <= w_timeout_next;
      r_grant0  <= (w_state_next == S_G0);
      r_grant1  <= (w_state_next == S_G1);
      r_busy    <= (w_state_next != S_IDLE);
    end
  end

  assign o_grant0  = r_grant0;
  assign o_grant1  = r_grant1;
  assign o_control = r_control;
  assign o_busy    = r_busy;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences and a random
// invariant run for the round-robin mux arbiter.
module tb_mux_arbiter;

  localparam int MAX_HOLD = 15;

  logic clk;
  logic rst_n;
  logic req0;
  logic req1;
  logic grant0;
  logic grant1;
  logic control;
  logic busy;
  logic timeout;

  int n_total  = 0;
  int n_passed = 0;

  mux_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req0   (req0),
    .i_req1   (req1),
    .o_grant0 (grant0),
    .o_grant1 (grant1),
    .o_control(control),
    .o_busy   (busy),
    .o_timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector order: {grant0, grant1, control, busy, timeout}
  typedef struct {
    logic       r0;
    logic       r1;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[21];

  function automatic logic [4:0] outs();
    return {grant0, grant1, control, busy, timeout};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got g0g1/ctl/busy/to=%b expected %b", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic step(input logic r0, input logic r1, input logic [4:0] exp, input string name);
    req0 = r0;
    req1 = r1;
    @(posedge clk);
    #1;
    check(name, outs(), exp);
  endtask

  int w0, w1;
  logic prev_ctl;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 5'b00000};
    vecs[1]  = '{1'b1, 1'b1, 5'b10010};  // tie after reset: requester 0 first
    vecs[2]  = '{1'b0, 1'b1, 5'b01110};  // release straight to G1, no bubble
    vecs[3]  = '{1'b0, 1'b0, 5'b00100};  // idle keeps control
    vecs[4]  = '{1'b1, 1'b0, 5'b10010};
    vecs[5]  = '{1'b0, 1'b0, 5'b00000};
    vecs[6]  = '{1'b1, 1'b1, 5'b01110};  // last served 0 -> tie to 1
    vecs[7]  = '{1'b1, 1'b0, 5'b10010};
    vecs[8]  = '{1'b0, 1'b1, 5'b01110};
    vecs[9]  = '{1'b1, 1'b1, 5'b01110};
    vecs[10] = '{1'b1, 1'b0, 5'b10010};
    vecs[11] = '{1'b0, 1'b1, 5'b01110};
    vecs[12] = '{1'b1, 1'b1, 5'b01110};
    vecs[13] = '{1'b0, 1'b0, 5'b00100};
    vecs[14] = '{1'b0, 1'b1, 5'b01110};
    vecs[15] = '{1'b0, 1'b0, 5'b00100};
    vecs[16] = '{1'b1, 1'b0, 5'b10010};
    vecs[17] = '{1'b1, 1'b1, 5'b10010};
    vecs[18] = '{1'b0, 1'b1, 5'b01110};  // owner drops while other waits
    vecs[19] = '{1'b1, 1'b1, 5'b01110};  // re-raised owner does not win back
    vecs[20] = '{1'b0, 1'b0, 5'b00100};

    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", outs(), 5'b00000);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++)
      step(vecs[i].r0, vecs[i].r1, vecs[i].exp, $sformatf("vec%0d", i));

    // Forced hand-over both ways with Req0 and Req1 held high
    step(1'b1, 1'b0, 5'b10010, "to_g0");
    for (int k = 1; k < MAX_HOLD; k++)
      step(1'b1, 1'b1, 5'b10010, $sformatf("hold0_%0d", k));
    step(1'b1, 1'b1, 5'b01111, "timeout_to_g1");
    for (int k = 1; k < MAX_HOLD; k++)
      step(1'b1, 1'b1, 5'b01110, $sformatf("hold1_%0d", k));
    step(1'b1, 1'b1, 5'b10011, "timeout_to_g0");
    step(1'b1, 1'b1, 5'b10010, "timeout_one_cycle");
    step(1'b0, 1'b1, 5'b01110, "rel_after_to");
    step(1'b0, 1'b0, 5'b00100, "idle_after_to");

    // Lone requester is never timed out
    for (int k = 0; k < 40; k++)
      step(1'b0, 1'b1, 5'b01110, $sformatf("solo1_%0d", k));
    step(1'b0, 1'b0, 5'b00100, "solo1_release");

    // Asynchronous clear mid-grant
    step(1'b0, 1'b1, 5'b01110, "pre_clear");
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", outs(), 5'b00000);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1'b1, 1'b1, 5'b10010, "post_clear_tie");
    step(1'b0, 1'b0, 5'b00000, "post_clear_idle");

    w0 = 0;
    w1 = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(7) == 0) req0 = ~req0;
      if ($urandom_range(7) == 0) req1 = ~req1;
      w0 = (req0 && !grant0) ? w0 + 1 : 0;
      w1 = (req1 && !grant1) ? w1 + 1 : 0;
      prev_ctl = control;
      @(posedge clk);
      #1;
      check_bit("rnd_mutex", grant0 & grant1, 1'b0);
      check_bit("rnd_busy", busy, grant0 | grant1);
      if (busy) check_bit("rnd_ctl_owner", control, grant1);
      else      check_bit("rnd_ctl_hold", control, prev_ctl);
      check_bit("rnd_wait0", (w0 <= MAX_HOLD + 1), 1'b1);
      check_bit("rnd_wait1", (w1 <= MAX_HOLD + 1), 1'b1);
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
